// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: bus widths, idle port values, FSM states.
// No logic; latency n/a.
// Backpressure n/a.
package mem_arbiter_pkg;

    localparam int ADDR_BUS  = 32;
    localparam int DATA_BUS  = 32;
    localparam int WIDTH_BUS = 4;

    localparam logic [ADDR_BUS-1:0]  ZERO_ADDR  = '0;
    localparam logic [DATA_BUS-1:0]  ZERO_WORD  = '0;
    localparam logic [WIDTH_BUS-1:0] ZERO_WIDTH = '0;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Purely combinational, zero latency.
// No backpressure; vld low when no request is set.
module rr_pick #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          vld
);

    // Candidate index for each search position, already wrapped.
    logic [PW-1:0] cand [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cand[i] = PW'((int'(ptr) + i) % N);
        end
    end

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!vld && req[cand[i]]) begin
                vld           = 1'b1;
                idx           = cand[i];
                gnt[cand[i]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters; MEM_ARB_TIMEOUT_EN bounds bursts.
// Grant 1 cycle after request; memory port follows the owner combinationally; handover without idle bubble.
// Losers simply wait with ce held high; the grant is their only ready indication.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_ce_i,
    input  logic [NUM_REQ-1:0]                req_we_i,
    input  logic [NUM_REQ-1:0][ADDR_BUS-1:0]  req_addr_i,
    input  logic [NUM_REQ-1:0][WIDTH_BUS-1:0] req_width_i,
    input  logic [NUM_REQ-1:0][DATA_BUS-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]                req_gnt_o,
    output logic [DATA_BUS-1:0]               req_data_o,
    output logic                              mem_ce_o,
    output logic                              mem_we_o,
    output logic [ADDR_BUS-1:0]               mem_addr_o,
    output logic [WIDTH_BUS-1:0]              mem_width_o,
    output logic [DATA_BUS-1:0]               mem_data_o,
    input  logic [DATA_BUS-1:0]               mem_data_i,
    output logic                              arb_err_o
);

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_bad_cfg
        $error("mem_arbiter: NUM_REQ must be 2..8 and MAX_BURST >= 1");
    end

    arb_state_t         state;
    logic [PW-1:0]      owner;
    logic [PW-1:0]      ptr;
    logic [NUM_REQ-1:0] gnt_q;

    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [PW-1:0]      pick_idx;
    logic               pick_vld;
    logic               owner_ce;
    logic               timeout;
    logic               release_now;

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] k);
        return (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
    endfunction

    assign owner_ce    = req_ce_i[owner];
    assign release_now = (state == STATE_GRANT) && (!owner_ce || timeout);

    // The releasing owner is masked so a same-cycle re-request cannot win the handover.
    assign pick_req = (state == STATE_GRANT) ? (req_ce_i & ~gnt_q) : req_ce_i;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req (pick_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] burst_cnt;
    logic          err_q;

    // Fires in the MAX_BURST-th granted cycle of a burst that is still requesting.
    assign timeout = (state == STATE_GRANT) && owner_ce && (burst_cnt == CW'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state == STATE_IDLE || release_now) begin
                burst_cnt <= '0;
            end else begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    assign arb_err_o = err_q;
`else
    assign timeout   = 1'b0;
    assign arb_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STATE_IDLE;
            owner <= '0;
            ptr   <= '0;
            gnt_q <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (pick_vld) begin
                        state <= STATE_GRANT;
                        owner <= pick_idx;
                        ptr   <= ptr_after(pick_idx);
                        gnt_q <= pick_gnt;
                    end
                end
                STATE_GRANT: begin
                    if (release_now) begin
                        if (pick_vld) begin
                            owner <= pick_idx;
                            ptr   <= ptr_after(pick_idx);
                            gnt_q <= pick_gnt;
                        end else begin
                            state <= STATE_IDLE;
                            gnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = ZERO_ADDR;
        mem_width_o = ZERO_WIDTH;
        mem_data_o  = ZERO_WORD;
        if (state == STATE_GRANT) begin
            mem_ce_o    = req_ce_i[owner];
            mem_we_o    = req_we_i[owner];
            mem_addr_o  = req_addr_i[owner];
            mem_width_o = req_width_i[owner];
            mem_data_o  = req_data_i[owner];
        end
    end

    assign req_gnt_o  = gnt_q;
    assign req_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a queue-level model.
// Outputs compared every falling edge; inputs driven 1 time unit after the rising edge.
// Honours MEM_ARB_TIMEOUT_EN when the bench is compiled with it.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int MB = 8;

    logic                              clk = 1'b0;
    logic                              rst = 1'b0;
    logic [N-1:0]                      req_ce_i;
    logic [N-1:0]                      req_we_i;
    logic [N-1:0][ADDR_BUS-1:0]        req_addr_i;
    logic [N-1:0][WIDTH_BUS-1:0]       req_width_i;
    logic [N-1:0][DATA_BUS-1:0]        req_data_i;
    logic [N-1:0]                      req_gnt_o;
    logic [DATA_BUS-1:0]               req_data_o;
    logic                              mem_ce_o;
    logic                              mem_we_o;
    logic [ADDR_BUS-1:0]               mem_addr_o;
    logic [WIDTH_BUS-1:0]              mem_width_o;
    logic [DATA_BUS-1:0]               mem_data_o;
    logic [DATA_BUS-1:0]               mem_data_i;
    logic                              arb_err_o;

    mem_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_ce_i    (req_ce_i),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_width_i (req_width_i),
        .req_data_i  (req_data_i),
        .req_gnt_o   (req_gnt_o),
        .req_data_o  (req_data_o),
        .mem_ce_o    (mem_ce_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_width_o (mem_width_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .arb_err_o   (arb_err_o)
    );

    always #5 clk = ~clk;

    int  n_cmp  = 0;
    int  n_bad  = 0;
    bit  chk_en = 1'b0;

    // Reference model: who owns the port, where the next search starts, burst length, error pulse.
    int  m_own = -1;
    int  m_ptr = 0;
    int  m_len = 0;
    bit  m_err = 1'b0;
    int  gnt_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin : model
        int own, ptr, len, excl;
        bit err, rel;
        if (!rst) begin
            m_own <= -1;
            m_ptr <= 0;
            m_len <= 0;
            m_err <= 1'b0;
        end else begin
            own  = m_own;
            ptr  = m_ptr;
            len  = m_len;
            err  = 1'b0;
            excl = -1;
            if (own >= 0) begin
                len = len + 1;
                rel = !req_ce_i[own];
`ifdef MEM_ARB_TIMEOUT_EN
                if (!rel && len == MB) begin
                    rel = 1'b1;
                    err = 1'b1;
                end
`endif
                if (rel) begin
                    excl = own;
                    own  = -1;
                end
            end
            if (own < 0) begin
                for (int i = 0; i < N; i++) begin
                    if (own < 0 && req_ce_i[(ptr + i) % N] && ((ptr + i) % N) != excl)
                        own = (ptr + i) % N;
                end
                if (own >= 0) begin
                    ptr = (own + 1) % N;
                    len = 0;
                    gnt_log.push_back(own);
                end
            end
            m_own <= own;
            m_ptr <= ptr;
            m_len <= len;
            m_err <= err;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (m_own >= 0) begin
                chk("gnt",   req_gnt_o,   N'(1) << m_own);
                chk("ce",    mem_ce_o,    req_ce_i[m_own]);
                chk("we",    mem_we_o,    req_we_i[m_own]);
                chk("addr",  mem_addr_o,  req_addr_i[m_own]);
                chk("width", mem_width_o, req_width_i[m_own]);
                chk("wdata", mem_data_o,  req_data_i[m_own]);
            end else begin
                chk("gnt_idle",   req_gnt_o,   0);
                chk("ce_idle",    mem_ce_o,    0);
                chk("we_idle",    mem_we_o,    0);
                chk("addr_idle",  mem_addr_o,  0);
                chk("width_idle", mem_width_o, 0);
                chk("wdata_idle", mem_data_o,  0);
            end
            chk("rdata", req_data_o, mem_data_i);
            chk("err",   arb_err_o,  m_err);
        end
    end

    task automatic rand_payload();
        for (int k = 0; k < N; k++) begin
            req_we_i[k]    = 1'($urandom);
            req_addr_i[k]  = $urandom;
            req_width_i[k] = 4'($urandom_range(1, 8));
            req_data_i[k]  = $urandom;
        end
        mem_data_i = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        rand_payload();
    endtask

    task automatic do_reset();
        next_cycle();
        req_ce_i = '0;
        rst      = 1'b0;
        next_cycle();
        rst      = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete within time budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base, held, cnt0, nerr;
        logic [N-1:0] last;
        int exp_ord[5];

        req_ce_i    = '0;
        req_we_i    = '0;
        req_addr_i  = '0;
        req_width_i = '0;
        req_data_i  = '0;
        mem_data_i  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        req_we_i = '1;
        chk("reset_gnt", req_gnt_o, 0);
        chk("reset_ce",  mem_ce_o,  0);
        chk("reset_we",  mem_we_o,  0);
        chk("reset_err", arb_err_o, 0);
        chk_en = 1'b1;
        rst    = 1'b1;

        // Read broadcast while idle
        next_cycle();
        mem_data_i = 32'hDEAD_BEEF;
        #1;
        chk("bcast_idle", req_data_o, 32'hDEAD_BEEF);

        // Single requester burst at 0x80..0x84
        do_reset();
        next_cycle();
        req_ce_i = 4'b0001;
        req_addr_i[0] = 32'h80;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            req_ce_i = 4'b0001;
            req_addr_i[0] = 32'h80 + i;
            if (i == 2) mem_data_i = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("single_gnt",  req_gnt_o,  4'b0001);
            chk("single_addr", mem_addr_o, 32'h80 + i);
            if (i == 2) chk("bcast_granted", req_data_o, 32'hDEAD_BEEF);
        end
        next_cycle();
        req_ce_i = '0;
        @(negedge clk);
        chk("single_rel_ce", mem_ce_o, 0);
        next_cycle();
        @(negedge clk);
        chk("single_idle_gnt", req_gnt_o, 0);
        chk("single_idle_ce",  mem_ce_o,  0);

        // Contention: all request, each owner drops ce once after 3 granted cycles
        do_reset();
        base = gnt_log.size();
        held = 0;
        last = '0;
        for (int c = 0; c < 60 && gnt_log.size() < base + 5; c++) begin
            next_cycle();
            req_ce_i = 4'b1111;
            if (req_gnt_o != '0) begin
                if (req_gnt_o == last) held++;
                else begin
                    held = 1;
                    last = req_gnt_o;
                end
                if (held > 3) req_ce_i = req_ce_i & ~req_gnt_o;
            end
            @(negedge clk);
            if (gnt_log.size() > base) chk("contention_busy", req_gnt_o != '0, 1);
        end
        exp_ord = '{0, 1, 2, 3, 0};
        chk("contention_count", gnt_log.size() - base, 5);
        if (gnt_log.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) chk("contention_order", gnt_log[base + i], exp_ord[i]);
        end

        // Pointer fairness: 2 granted and released, then 0101 goes to 0
        do_reset();
        next_cycle(); req_ce_i = 4'b0100;
        next_cycle(); req_ce_i = 4'b0100;
        @(negedge clk);
        chk("fair_first", req_gnt_o, 4'b0100);
        next_cycle(); req_ce_i = 4'b0000;
        next_cycle(); req_ce_i = 4'b0000;
        next_cycle(); req_ce_i = 4'b0101;
        next_cycle(); req_ce_i = 4'b0101;
        @(negedge clk);
        chk("fair_wrap", req_gnt_o, 4'b0001);

        // Asynchronous reset mid-burst
        do_reset();
        next_cycle(); req_ce_i = 4'b0010; req_we_i = 4'b0010;
        next_cycle(); req_ce_i = 4'b0010; req_we_i = 4'b0010;
        @(negedge clk);
        chk("rst_pre_gnt", req_gnt_o, 4'b0010);
        chk("rst_pre_we",  mem_we_o,  1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_gnt", req_gnt_o, 0);
        chk("rst_async_ce",  mem_ce_o,  0);
        chk("rst_async_we",  mem_we_o,  0);
        next_cycle();
        rst = 1'b1;
        req_ce_i = 4'b1010;
        next_cycle();
        req_ce_i = 4'b1010;
        @(negedge clk);
        chk("rst_regrant", req_gnt_o, 4'b0010);

        // Long burst by 0 while 3 waits
        do_reset();
        cnt0 = 0;
        nerr = 0;
        for (int c = 0; c < 16; c++) begin
            next_cycle();
            req_ce_i = 4'b1001;
            @(negedge clk);
            if (req_gnt_o == 4'b0001) cnt0++;
            if (arb_err_o) nerr++;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        chk("timeout_len",   cnt0, MB);
        chk("timeout_err",   nerr, 1);
        chk("timeout_owner", req_gnt_o, 4'b1000);
`else
        chk("unbounded_len", cnt0, 15);
        chk("no_err",        nerr, 0);
        chk("unbounded_own", req_gnt_o, 4'b0001);
`endif

        // Randomized traffic with one asynchronous reset pulse mid-cycle
        do_reset();
        for (int c = 0; c < 800; c++) begin
            next_cycle();
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) req_ce_i[k] = ~req_ce_i[k];
            end
            if (c == 400) begin
                #2 rst = 1'b0;
                #3 rst = 1'b1;
            end
        end

        next_cycle();
        req_ce_i = '0;
        repeat (2) next_cycle();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
